// File: rtl/sram_mem_ctrl.sv
// Multi-cycle load/store controller: one pipeline word as BEATS narrow async-SRAM accesses.
// Latency BEATS*(WAIT_CYCLES+1)+1 cycles (1 if out of range); ready low freezes the pipeline meanwhile.
module sram_mem_ctrl #(
    parameter int WORD_WIDTH      = 32,
    parameter int SRAM_WIDTH      = 16,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int WAIT_CYCLES     = 1,
    parameter int BASE_ADDR       = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [31:0]                address,
    input  logic [WORD_WIDTH-1:0]      write_data,
    output logic [WORD_WIDTH-1:0]      read_data,
    output logic                       ready,
    output logic                       addr_err,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_WIDTH-1:0]      sram_dq_out,
    input  logic [SRAM_WIDTH-1:0]      sram_dq_in,
    output logic                       sram_dq_oe,
    output logic                       sram_we_n
);
    localparam int BEATS = WORD_WIDTH / SRAM_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WCW   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [BW-1:0]  LAST_BEAT = BW'(BEATS - 1);
    localparam logic [WCW-1:0] LAST_WAIT = WCW'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                     state_q;
    logic                       op_wr_q;
    logic                       addr_err_q;
    logic [BW-1:0]              beat_q;
    logic [WCW-1:0]             wait_q;
    logic [WORD_WIDTH-1:0]      wsh_q;
    logic [WORD_WIDTH-1:0]      rbuf_q;
    logic [WORD_WIDTH-1:0]      read_data_q;
    logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q;
    logic [SRAM_WIDTH-1:0]      sram_dq_out_q;
    logic                       sram_dq_oe_q;
    logic                       sram_we_n_q;

    logic [31:0]           offset_d;
    logic [63:0]           first_beat_d;
    logic [63:0]           last_beat_d;
    logic                  out_of_range_d;
    logic [WORD_WIDTH-1:0] rbuf_d;

    always_comb begin
        offset_d       = address - 32'(BASE_ADDR);
        first_beat_d   = 64'(offset_d >> 2) * 64'(BEATS);
        last_beat_d    = first_beat_d + 64'(BEATS - 1);
        out_of_range_d = (address < 32'(BASE_ADDR)) ||
                         (last_beat_d >= (64'd1 << SRAM_ADDR_WIDTH));
        // Beats shift in from the top so beat 0 ends up in the LSBs.
        rbuf_d         = WORD_WIDTH'({sram_dq_in, rbuf_q} >> SRAM_WIDTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            op_wr_q       <= 1'b0;
            addr_err_q    <= 1'b0;
            beat_q        <= '0;
            wait_q        <= '0;
            wsh_q         <= '0;
            rbuf_q        <= '0;
            read_data_q   <= '0;
            sram_addr_q   <= '0;
            sram_dq_out_q <= '0;
            sram_dq_oe_q  <= 1'b0;
            sram_we_n_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_en || rd_en) begin
                        op_wr_q <= wr_en;
                        beat_q  <= '0;
                        wait_q  <= '0;
                        if (out_of_range_d) begin
                            state_q    <= DONE;
                            addr_err_q <= 1'b1;
                            if (!wr_en) read_data_q <= '0;
                        end else begin
                            state_q       <= ACCESS;
                            sram_addr_q   <= SRAM_ADDR_WIDTH'(first_beat_d);
                            sram_dq_out_q <= write_data[SRAM_WIDTH-1:0];
                            wsh_q         <= write_data >> SRAM_WIDTH;
                            sram_dq_oe_q  <= wr_en;
                            sram_we_n_q   <= !wr_en;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_q == LAST_WAIT) begin
                        wait_q <= '0;
                        if (!op_wr_q) rbuf_q <= rbuf_d;
                        if (beat_q == LAST_BEAT) begin
                            state_q      <= DONE;
                            sram_we_n_q  <= 1'b1;
                            sram_dq_oe_q <= 1'b0;
                            if (!op_wr_q) read_data_q <= rbuf_d;
                        end else begin
                            beat_q        <= beat_q + BW'(1);
                            sram_addr_q   <= sram_addr_q + SRAM_ADDR_WIDTH'(1);
                            sram_dq_out_q <= wsh_q[SRAM_WIDTH-1:0];
                            wsh_q         <= wsh_q >> SRAM_WIDTH;
                        end
                    end else begin
                        wait_q <= wait_q + WCW'(1);
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    addr_err_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Requests seen in DONE belong to the instruction leaving the stage.
    assign ready       = (state_q == DONE) || ((state_q == IDLE) && !(rd_en || wr_en));
    assign read_data   = read_data_q;
    assign addr_err    = addr_err_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = sram_dq_out_q;
    assign sram_dq_oe  = sram_dq_oe_q;
    assign sram_we_n   = sram_we_n_q;
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench: default instance (16-bit SRAM, 1 wait) plus an 8-bit zero-wait instance.
module tb_sram_mem_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        wr_a, rd_a, ready_a, err_a, oe_a, we_n_a;
    logic [31:0] addr_a, wdat_a, rdat_a;
    logic [17:0] sa_a;
    logic [15:0] dqo_a, dqi_a;
    logic [15:0] mem_a [0:15];

    logic        wr_b, rd_b, ready_b, err_b, oe_b, we_n_b;
    logic [31:0] addr_b, wdat_b, rdat_b;
    logic [17:0] sa_b;
    logic [7:0]  dqo_b, dqi_b;
    logic [7:0]  mem_b [0:15];

    sram_mem_ctrl dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_a), .rd_en(rd_a), .address(addr_a),
        .write_data(wdat_a), .read_data(rdat_a), .ready(ready_a), .addr_err(err_a),
        .sram_addr(sa_a), .sram_dq_out(dqo_a), .sram_dq_in(dqi_a),
        .sram_dq_oe(oe_a), .sram_we_n(we_n_a)
    );

    sram_mem_ctrl #(.SRAM_WIDTH(8), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_b), .rd_en(rd_b), .address(addr_b),
        .write_data(wdat_b), .read_data(rdat_b), .ready(ready_b), .addr_err(err_b),
        .sram_addr(sa_b), .sram_dq_out(dqo_b), .sram_dq_in(dqi_b),
        .sram_dq_oe(oe_b), .sram_we_n(we_n_b)
    );

    // Async SRAM models: combinational read, write captured while we_n is low.
    assign dqi_a = mem_a[sa_a[3:0]];
    assign dqi_b = mem_b[sa_b[3:0]];
    always @(posedge clk) if (!we_n_a && oe_a) mem_a[sa_a[3:0]] <= dqo_a;
    always @(posedge clk) if (!we_n_b && oe_b) mem_b[sa_b[3:0]] <= dqo_b;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] exp_rdat;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
        int          sa0;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdat,
                                input logic [31:0] exp_rdat, input logic exp_err, input int sa0);
        vec_t v;
        v.wr       = wr;
        v.addr     = addr;
        v.wdat     = wdat;
        v.exp_rdat = exp_rdat;
        v.exp_err  = exp_err;
        v.exp_lat  = exp_err ? 1 : 5;
        v.exp_we   = (wr && !exp_err) ? 4 : 0;
        v.sa0      = sa0;
        return v;
    endfunction

    // Called #1 after a rising edge with dut_a idle; returns #1 after the edge following DONE.
    task automatic run_vec(input vec_t v, input string tag);
        int  cyc;
        int  we_cnt;
        bit  done;
        wr_a = v.wr; rd_a = !v.wr; addr_a = v.addr; wdat_a = v.wdat;
        #1;
        chk({tag, "_ready_c0"}, 32'(ready_a), 32'(0));
        cyc = 0; we_cnt = 0; done = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (!we_n_a) we_cnt++;
            if (ready_a) done = 1;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(v.exp_lat));
        chk({tag, "_addr_err"}, 32'(err_a), 32'(v.exp_err));
        chk({tag, "_read_data"}, rdat_a, v.exp_rdat);
        chk({tag, "_we_cycles"}, 32'(we_cnt), 32'(v.exp_we));
        if (v.wr && !v.exp_err) begin
            chk({tag, "_mem_lo"}, 32'(mem_a[v.sa0[3:0]]), 32'(v.wdat[15:0]));
            chk({tag, "_mem_hi"}, 32'(mem_a[4'(v.sa0 + 1)]), 32'(v.wdat[31:16]));
        end
        wr_a = 0; rd_a = 0;
        @(posedge clk); #1;
        chk({tag, "_idle_ready"}, 32'(ready_a), 32'(1));
        chk({tag, "_err_clear"}, 32'(err_a), 32'(0));
        chk({tag, "_rdata_held"}, rdat_a, v.exp_rdat);
    endtask

    task automatic run_b(input logic wr, input logic [31:0] addr, input logic [31:0] wdat,
                         input logic [31:0] exp_rd, input string tag);
        wr_b = wr; rd_b = !wr; addr_b = addr; wdat_b = wdat;
        #1;
        chk({tag, "_ready_c0"}, 32'(ready_b), 32'(0));
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c <= 4) begin
                chk($sformatf("%s_sram_addr_c%0d", tag, c), 32'(sa_b), 32'(3 + c));
                chk($sformatf("%s_ready_c%0d", tag, c), 32'(ready_b), 32'(0));
                chk($sformatf("%s_we_n_c%0d", tag, c), 32'(we_n_b), 32'(!wr));
            end else begin
                chk({tag, "_ready_done"}, 32'(ready_b), 32'(1));
                chk({tag, "_err"}, 32'(err_b), 32'(0));
                chk({tag, "_read_data"}, rdat_b, exp_rd);
            end
        end
        wr_b = 0; rd_b = 0;
        @(posedge clk); #1;
    endtask

    vec_t vecs [10];
    vec_t v;
    int   we_cnt;

    initial begin
        vecs[0] = mk(1'b1, 32'd1024,   32'hDEADBEEF, 32'h00000000, 1'b0, 0);
        vecs[1] = mk(1'b0, 32'd1024,   32'h0,        32'hDEADBEEF, 1'b0, 0);
        vecs[2] = mk(1'b0, 32'd1020,   32'h0,        32'h00000000, 1'b1, 0);
        vecs[3] = mk(1'b1, 32'd525308, 32'h12345678, 32'h00000000, 1'b0, 14);
        vecs[4] = mk(1'b0, 32'd525312, 32'h0,        32'h00000000, 1'b1, 0);
        vecs[5] = mk(1'b0, 32'd525308, 32'h0,        32'h12345678, 1'b0, 0);
        vecs[6] = mk(1'b1, 32'd1026,   32'hCAFEF00D, 32'h12345678, 1'b0, 0);
        vecs[7] = mk(1'b0, 32'd1027,   32'h0,        32'hCAFEF00D, 1'b0, 0);
        vecs[8] = mk(1'b1, 32'd1020,   32'hFFFFFFFF, 32'hCAFEF00D, 1'b1, 0);
        vecs[9] = mk(1'b0, 32'd1024,   32'h0,        32'hCAFEF00D, 1'b0, 0);

        rst = 1'b1;
        wr_a = 0; rd_a = 0; addr_a = '0; wdat_a = '0;
        wr_b = 0; rd_b = 0; addr_b = '0; wdat_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready_a), 32'(1));
        chk("rst_read_data", rdat_a, 32'h0);
        chk("rst_addr_err", 32'(err_a), 32'(0));
        chk("rst_sram_addr", 32'(sa_a), 32'(0));
        chk("rst_dq_out", 32'(dqo_a), 32'(0));
        chk("rst_dq_oe", 32'(oe_a), 32'(0));
        chk("rst_we_n", 32'(we_n_a), 32'(1));
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset during the second beat of a write: only beat 0 reaches the SRAM.
        wr_a = 1; addr_a = 32'd1024; wdat_a = 32'hAAAA5555;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_we_n_before", 32'(we_n_a), 32'(0));
        chk("midrst_beat1_addr", 32'(sa_a), 32'(1));
        rst = 1'b1; wr_a = 0;
        #1;
        chk("midrst_we_n", 32'(we_n_a), 32'(1));
        chk("midrst_sram_addr", 32'(sa_a), 32'(0));
        chk("midrst_dq_oe", 32'(oe_a), 32'(0));
        chk("midrst_dq_out", 32'(dqo_a), 32'(0));
        chk("midrst_read_data", rdat_a, 32'h0);
        chk("midrst_ready", 32'(ready_a), 32'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        v = mk(1'b0, 32'd1024, 32'h0, 32'hCAFE5555, 1'b0, 0);
        run_vec(v, "after_rst");

        // Both enables high (write wins), then a read held through DONE.
        wr_a = 1; rd_a = 1; addr_a = 32'd1024; wdat_a = 32'h0BADCAFE;
        #1;
        chk("b2b_ready_c0", 32'(ready_a), 32'(0));
        we_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 1) wr_a = 0;
            if (!we_n_a) we_cnt++;
            chk($sformatf("b2b_ready_c%0d", c), 32'(ready_a), 32'((c == 5) || (c >= 11)));
            if (c == 11) begin
                chk("b2b_read_data", rdat_a, 32'h0BADCAFE);
                rd_a = 0;
            end
        end
        chk("b2b_we_cycles", 32'(we_cnt), 32'(4));

        // Narrow zero-wait instance: one beat per cycle at SRAM words 4..7.
        run_b(1'b1, 32'd1028, 32'h44332211, 32'h00000000, "narrow_wr");
        run_b(1'b0, 32'd1028, 32'h0, 32'h44332211, "narrow_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Multi-cycle data-memory controller that replaces the single-cycle data memory inside the memory stage of the 5-stage ARM pipeline.
- Converts one WORD_WIDTH load/store from the pipeline into BEATS = WORD_WIDTH/SRAM_WIDTH narrow accesses to an external asynchronous SRAM. Each access has programmable wait states.
- Drives ready low while busy; the top level uses ~ready as the global freeze for all pipeline registers and the PC.

Parameters:
WORD_WIDTH, 32, pipeline data width.
SRAM_WIDTH, 16, SRAM data-bus width; WORD_WIDTH must be an integer multiple of it.
SRAM_ADDR_WIDTH, 18, SRAM address width, in SRAM words.
WAIT_CYCLES, 1, extra cycles each beat is held (0 or more).
BASE_ADDR, 1024, byte address that maps to SRAM word 0.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wr_en  in  1  store request from the memory stage
rd_en  in  1  load request from the memory stage
address  in  32  byte address (ALU result)
write_data  in  WORD_WIDTH  store data (val_Rm)
read_data  out  WORD_WIDTH  load result
ready  out  1  1 = request complete or controller idle; 0 = freeze pipeline
addr_err  out  1  one-cycle pulse when a request was out of range
sram_addr  out  SRAM_ADDR_WIDTH  SRAM address
sram_dq_out  out  SRAM_WIDTH  write data to SRAM
sram_dq_in  in  SRAM_WIDTH  read data from SRAM
sram_dq_oe  out  1  1 = controller drives the DQ bus
sram_we_n  out  1  active-low SRAM write enable

Behaviour:
- Interface: one clock, clk. rst is asynchronous and active-high.
- Reset values: state IDLE, read_data 0, addr_err 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1. Beat and wait counters are 0.
- Reset asserted mid-operation forces IDLE immediately, with no clock edge needed. sram_we_n returns to 1 and the partial write is abandoned.
- Address translation: word_idx = (address - BASE_ADDR) >> 2. address[1:0] is ignored. SRAM address for beat b = word_idx*BEATS + b.
- Range check: the request is out of range if address < BASE_ADDR or word_idx*BEATS + BEATS - 1 >= 2^SRAM_ADDR_WIDTH.
- States are IDLE, ACCESS, DONE.
  - IDLE:
    - With no request, ready = 1.
    - When rd_en or wr_en is high, ready = 0 combinationally in that same cycle.
    - At the next edge, the controller latches address, write_data and the operation. wr_en takes priority if both are high.
    - An in-range request goes to ACCESS with beat = 0 and wait = 0.
    - An out-of-range request goes to DONE directly, with no SRAM activity and sram_we_n kept at 1.
  - ACCESS:
    - ready = 0.
    - Each beat lasts WAIT_CYCLES+1 cycles.
    - sram_addr, sram_dq_out, sram_dq_oe and sram_we_n are registered and stay stable for the whole beat.
    - Write: sram_dq_oe = 1, sram_we_n = 0, sram_dq_out = write_data slice b. Beat 0 carries the LSBs.
    - Read: sram_dq_oe = 0, sram_we_n = 1. In the last cycle of beat b, sram_dq_in is sampled into read-buffer slice b.
    - After the last cycle of beat BEATS-1, go to DONE.
  - DONE:
    - Lasts one cycle, with ready = 1 and sram_we_n = 1.
    - For a read, read_data shows the assembled word in this cycle.
    - For an out-of-range request: read_data = 0 on a read, and addr_err = 1 for this cycle.
    - rd_en/wr_en are ignored in DONE, since they belong to the instruction now leaving. Next state is IDLE.
- Latency: with N = BEATS*(WAIT_CYCLES+1), ready is low for N+1 cycles and high in cycle N+1, counting the request cycle as cycle 0. Defaults give N = 4, so ready is low in cycles 0–4 and high in cycle 5. An out-of-range request gives ready low in cycle 0 and high in cycle 1.
- read_data holds its value until the next read completes. Writes do not change it.
- Back-to-back: a request still present in the cycle after DONE starts a new transaction from IDLE.

Test Plan:
1. Defaults; write address 1024, data 0xDEADBEEF -> sram_addr 0 carries 0xBEEF and sram_addr 1 carries 0xDEAD. we_n is low for 2 cycles per beat. ready is low in cycles 0–4 and high in cycle 5.
2. Read address 1024, SRAM model returns the stored data -> read_data = 0xDEADBEEF in the DONE cycle and held afterwards. ready timing is the same as scenario 1.
3. Read address 1020 and read address BASE_ADDR + 2^SRAM_ADDR_WIDTH*2 -> no SRAM strobes. ready high in cycle 1, addr_err pulses, read_data = 0.
4. Assert rst in the second beat of a write -> sram_we_n = 1 without a clock edge. Outputs return to reset values. A following read of the same word shows only beat 0 updated.
5. WAIT_CYCLES = 0, SRAM_WIDTH = 8; read address 1028 -> sram_addr 4..7 accessed one per cycle. ready low for 5 cycles. read_data assembled LSB first.
6. rd_en and wr_en both high, then a second request held through DONE -> the first is executed as a write. The second starts in the cycle after DONE, with exactly one transaction per request.
